// File: rtl/powerup_effects_pkg.sv
// Shared gift-kind codes and default effect constants used by the gift stage
// and powerup_effects.
package powerup_effects_pkg;

  typedef enum logic [2:0] {
    CHP = 3'd0,
    SPP = 3'd1,
    GBL = 3'd2,
    SPB = 3'd3,
    CHB = 3'd4,
    HID = 3'd5,
    SOT = 3'd6,
    DRP = 3'd7
  } gift_kind_e;

  localparam int DEF_TW        = 10;
  localparam int DEF_DUR_TICKS = 600;
  localparam int DEF_SHOT_W    = 3;
  localparam int DEF_SHOT_ADD  = 3;
  localparam int DEF_MAX_SHOTS = 7;

endpackage

// File: rtl/powerup_effects_if.sv
// Bundle between the gift stage and game logic (master) and powerup_effects
// (slave).
interface powerup_effects_if
  import powerup_effects_pkg::*;
#(
  parameter int SHOT_W = DEF_SHOT_W
);
  logic              tick;
  logic              clear;
  logic              paddle_size;
  logic              paddle_speed;
  logic              give_ball;
  logic              ball_speed;
  logic              ball_size;
  logic              ball_display;
  logic              get_shot;
  logic              drop_block;
  logic              fire;
  logic              ball_ack;
  logic              drop_ack;
  logic              wide_paddle;
  logic              fast_paddle;
  logic              fast_ball;
  logic              big_ball;
  logic              ball_hidden;
  logic [SHOT_W-1:0] shots;
  logic              shot_fire;
  logic              ball_req;
  logic              drop_req;

  modport master (
    output tick, clear, paddle_size, paddle_speed, give_ball, ball_speed,
           ball_size, ball_display, get_shot, drop_block, fire, ball_ack, drop_ack,
    input  wide_paddle, fast_paddle, fast_ball, big_ball, ball_hidden,
           shots, shot_fire, ball_req, drop_req
  );

  modport slave (
    input  tick, clear, paddle_size, paddle_speed, give_ball, ball_speed,
           ball_size, ball_display, get_shot, drop_block, fire, ball_ack, drop_ack,
    output wide_paddle, fast_paddle, fast_ball, big_ball, ball_hidden,
           shots, shot_fire, ball_req, drop_req
  );

endinterface

// File: rtl/powerup_effects_effect_timer.sv
// effect_timer: one timed effect. A load sets the lifetime, tick counts it down,
// and active is high while the count is nonzero.
module effect_timer
  import powerup_effects_pkg::*;
#(
  parameter int TW        = DEF_TW,
  parameter int DUR_TICKS = DEF_DUR_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic tick,
  input  logic clear,
  output logic active
);

  logic [TW-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign a default first so no path leaves a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (load)
      cnt_d = TW'(DUR_TICKS);
    else if (tick && cnt_q != '0)
      cnt_d = cnt_q - TW'(1);
  end

  // active follows the next count, so it rises on the load edge and falls on
  // the edge of the final tick.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      active <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      active <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/powerup_effects.sv
// powerup_effects: turns gift-hit pulses into held effects, a shot budget and
// req/ack grants. Define POWERUP_HIDE_EN to build the ball_hidden timer.
module powerup_effects
  import powerup_effects_pkg::*;
#(
  parameter int DUR_TICKS = DEF_DUR_TICKS,
  parameter int TW        = DEF_TW,
  parameter int SHOT_W    = DEF_SHOT_W,
  parameter int SHOT_ADD  = DEF_SHOT_ADD,
  parameter int MAX_SHOTS = DEF_MAX_SHOTS
) (
  input logic              clock,
  input logic              reset,
  powerup_effects_if.slave bus
);

  localparam logic [SHOT_W:0] ADD_EXT = (SHOT_W+1)'(SHOT_ADD);
  localparam logic [SHOT_W:0] MAX_EXT = (SHOT_W+1)'(MAX_SHOTS);

  effect_timer #(.TW(TW), .DUR_TICKS(DUR_TICKS)) u_wide (
    .clock(clock), .reset(reset), .load(bus.paddle_size), .tick(bus.tick),
    .clear(bus.clear), .active(bus.wide_paddle)
  );

  effect_timer #(.TW(TW), .DUR_TICKS(DUR_TICKS)) u_fast_paddle (
    .clock(clock), .reset(reset), .load(bus.paddle_speed), .tick(bus.tick),
    .clear(bus.clear), .active(bus.fast_paddle)
  );

  effect_timer #(.TW(TW), .DUR_TICKS(DUR_TICKS)) u_fast_ball (
    .clock(clock), .reset(reset), .load(bus.ball_speed), .tick(bus.tick),
    .clear(bus.clear), .active(bus.fast_ball)
  );

  effect_timer #(.TW(TW), .DUR_TICKS(DUR_TICKS)) u_big_ball (
    .clock(clock), .reset(reset), .load(bus.ball_size), .tick(bus.tick),
    .clear(bus.clear), .active(bus.big_ball)
  );

`ifdef POWERUP_HIDE_EN
  effect_timer #(.TW(TW), .DUR_TICKS(DUR_TICKS)) u_hidden (
    .clock(clock), .reset(reset), .load(bus.ball_display), .tick(bus.tick),
    .clear(bus.clear), .active(bus.ball_hidden)
  );
`else
  logic hide_unused;
  assign hide_unused     = bus.ball_display;
  assign bus.ball_hidden = 1'b0;
`endif

  logic [SHOT_W-1:0] shots_q, shots_d;
  logic [SHOT_W:0]   shot_sum;
  logic              accept;
  logic              shot_fire_q;
  logic [1:0]        ball_cnt_q, ball_cnt_d;
  logic              ball_ack_ok;
  logic              drop_q, drop_d;

  // The sum is one bit wider than shots so a grant on top of a near-full
  // budget saturates instead of wrapping.
  always_comb begin
    accept   = bus.fire && (shots_q != '0) && !bus.clear;
    shot_sum = {1'b0, shots_q} - (SHOT_W+1)'(accept)
             + (bus.get_shot ? ADD_EXT : '0);
    shots_d  = (shot_sum > MAX_EXT) ? MAX_EXT[SHOT_W-1:0] : shot_sum[SHOT_W-1:0];
    if (bus.clear)
      shots_d = '0;
  end

  // A grant and a consumed ack in the same cycle cancel, even when saturated.
  always_comb begin
    ball_ack_ok = bus.ball_ack && (ball_cnt_q != 2'd0);
    ball_cnt_d  = ball_cnt_q;
    if (bus.clear)
      ball_cnt_d = 2'd0;
    else if (bus.give_ball && ball_ack_ok)
      ball_cnt_d = ball_cnt_q;
    else if (bus.give_ball && ball_cnt_q != 2'd3)
      ball_cnt_d = ball_cnt_q + 2'd1;
    else if (ball_ack_ok)
      ball_cnt_d = ball_cnt_q - 2'd1;
  end

  // A new drop_block outranks the ack so a coincident grant is never lost.
  always_comb begin
    drop_d = drop_q;
    if (bus.clear)
      drop_d = 1'b0;
    else if (bus.drop_block)
      drop_d = 1'b1;
    else if (bus.drop_ack && drop_q)
      drop_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shots_q     <= '0;
      shot_fire_q <= 1'b0;
      ball_cnt_q  <= 2'd0;
      drop_q      <= 1'b0;
    end else begin
      shots_q     <= shots_d;
      shot_fire_q <= accept;
      ball_cnt_q  <= ball_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.shots     = shots_q;
  assign bus.shot_fire = shot_fire_q;
  assign bus.ball_req  = (ball_cnt_q != 2'd0);
  assign bus.drop_req  = drop_q;

endmodule

// File: tb/tb_powerup_effects.sv
// Directed self-checking bench for powerup_effects with default parameters.
module tb_powerup_effects;
  import powerup_effects_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

`ifdef POWERUP_HIDE_EN
  localparam logic HIDE_EXP = 1'b1;
`else
  localparam logic HIDE_EXP = 1'b0;
`endif

  powerup_effects_if #(.SHOT_W(3)) b ();

  powerup_effects #(
    .DUR_TICKS(600), .TW(10), .SHOT_W(3), .SHOT_ADD(3), .MAX_SHOTS(7)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (b.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    b.tick = 0; b.clear = 0; b.paddle_size = 0; b.paddle_speed = 0;
    b.give_ball = 0; b.ball_speed = 0; b.ball_size = 0; b.ball_display = 0;
    b.get_shot = 0; b.drop_block = 0; b.fire = 0; b.ball_ack = 0; b.drop_ack = 0;
  endtask

  // Inputs set at a falling edge are sampled by the next rising edge; results
  // are observed at the following falling edge.
  task automatic step();
    @(negedge clock);
    zero_inputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      b.tick = 1;
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wide"}, 32'(b.wide_paddle), 0);
    check({tag, ".fpad"}, 32'(b.fast_paddle), 0);
    check({tag, ".fball"}, 32'(b.fast_ball), 0);
    check({tag, ".big"}, 32'(b.big_ball), 0);
    check({tag, ".hid"}, 32'(b.ball_hidden), 0);
    check({tag, ".shots"}, 32'(b.shots), 0);
    check({tag, ".sfire"}, 32'(b.shot_fire), 0);
    check({tag, ".breq"}, 32'(b.ball_req), 0);
    check({tag, ".dreq"}, 32'(b.drop_req), 0);
  endtask

  initial begin
    zero_inputs();
    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1;
    step();
    check_all_zero("post_reset");

    // Timer expiry: 600 ticks after the load.
    b.paddle_size = 1; step();
    check("wide_on", 32'(b.wide_paddle), 1);
    ticks(599);
    check("wide_599", 32'(b.wide_paddle), 1);
    ticks(1);
    check("wide_600", 32'(b.wide_paddle), 0);

    // Retrigger on the 300th tick: lasts until tick 900.
    b.paddle_size = 1; step();
    ticks(299);
    b.paddle_size = 1; b.tick = 1; step();
    ticks(599);
    check("retrig_899", 32'(b.wide_paddle), 1);
    ticks(1);
    check("retrig_900", 32'(b.wide_paddle), 0);

    // Load beats tick when the counter is 1.
    b.ball_speed = 1; step();
    ticks(599);
    check("fball_cnt1", 32'(b.fast_ball), 1);
    b.ball_speed = 1; b.tick = 1; step();
    check("fball_load_tick", 32'(b.fast_ball), 1);
    ticks(599);
    check("fball_reload_599", 32'(b.fast_ball), 1);
    ticks(1);
    check("fball_reload_600", 32'(b.fast_ball), 0);

    // Shot saturation.
    b.get_shot = 1; step();
    check("shots_3", 32'(b.shots), 3);
    b.get_shot = 1; step();
    check("shots_6", 32'(b.shots), 6);
    b.get_shot = 1; step();
    check("shots_sat", 32'(b.shots), 7);

    // Eight fires drain seven shots.
    for (int k = 1; k <= 8; k++) begin
      b.fire = 1; step();
      check($sformatf("fire%0d.pulse", k), 32'(b.shot_fire), (k <= 7) ? 1 : 0);
      check($sformatf("fire%0d.shots", k), 32'(b.shots), (k <= 7) ? 32'(7 - k) : 0);
    end

    b.get_shot = 1; b.fire = 1; step();
    check("refill.shots", 32'(b.shots), 3);
    check("refill.pulse", 32'(b.shot_fire), 0);
    b.get_shot = 1; b.fire = 1; step();
    check("fire_grant.shots", 32'(b.shots), 5);
    check("fire_grant.pulse", 32'(b.shot_fire), 1);
    b.get_shot = 1; b.fire = 1; step();
    check("fire_grant_sat", 32'(b.shots), 7);

    // Ball handshake.
    for (int k = 0; k < 4; k++) begin
      b.give_ball = 1; step();
    end
    check("ball_req_sat", 32'(b.ball_req), 1);
    b.give_ball = 1; b.ball_ack = 1; step();
    check("ball_give_ack3", 32'(b.ball_req), 1);
    b.ball_ack = 1; step();
    check("ball_ack1", 32'(b.ball_req), 1);
    b.ball_ack = 1; step();
    check("ball_ack2", 32'(b.ball_req), 1);
    b.ball_ack = 1; step();
    check("ball_ack3", 32'(b.ball_req), 0);
    b.ball_ack = 1; step();
    check("ball_ack_idle", 32'(b.ball_req), 0);
    b.give_ball = 1; step();
    check("ball_one", 32'(b.ball_req), 1);
    b.give_ball = 1; b.ball_ack = 1; step();
    check("ball_give_ack1", 32'(b.ball_req), 1);
    b.ball_ack = 1; step();
    check("ball_last_ack", 32'(b.ball_req), 0);

    // Drop merge.
    b.drop_block = 1; step();
    check("drop_rise", 32'(b.drop_req), 1);
    b.drop_block = 1; step();
    b.drop_ack = 1; step();
    check("drop_merged_ack", 32'(b.drop_req), 0);
    b.drop_block = 1; step();
    b.drop_block = 1; b.drop_ack = 1; step();
    check("drop_blk_ack", 32'(b.drop_req), 1);
    b.drop_ack = 1; step();
    check("drop_cleared", 32'(b.drop_req), 0);

    // Hide effect depends on build option.
    b.ball_display = 1; step();
    check("hidden", 32'(b.ball_hidden), 32'(HIDE_EXP));

    // Clear with everything active and coincident triggers.
    b.paddle_size = 1; b.paddle_speed = 1; b.ball_speed = 1; b.ball_size = 1;
    b.ball_display = 1; b.give_ball = 1; b.drop_block = 1; step();
    check("pre_clear.fpad", 32'(b.fast_paddle), 1);
    check("pre_clear.big", 32'(b.big_ball), 1);
    check("pre_clear.breq", 32'(b.ball_req), 1);
    b.clear = 1; b.fire = 1; b.get_shot = 1; b.paddle_size = 1; b.paddle_speed = 1;
    b.ball_speed = 1; b.ball_size = 1; b.ball_display = 1; b.give_ball = 1;
    b.drop_block = 1; b.tick = 1; step();
    check_all_zero("clear");
    ticks(3);
    check_all_zero("after_clear");

    // Asynchronous reset mid-operation.
    b.paddle_size = 1; b.give_ball = 1; b.drop_block = 1; b.get_shot = 1; step();
    check("pre_rst.wide", 32'(b.wide_paddle), 1);
    check("pre_rst.shots", 32'(b.shots), 3);
    #2 reset = 0;
    #1 check_all_zero("async_rst");
    @(negedge clock);
    reset = 1;
    step();
    check_all_zero("rst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
